softex_row_serializer: RTL and testbench
========================================

# softex_row_serializer

Consumer-side counterpart of the softex multi-row delay line. Accepts one strobed beat of `NUM_ROWS` rows over valid/ready and emits only the strobed rows, one per cycle, lowest index first, each tagged with its row index and a last-row flag. Sits between the row-parallel datapath output and narrow single-row sinks such as the accumulator writeback and streamer.

## Interface
Parameters:
- `NUM_ROWS`, 4: rows per input beat (≥1).
- `DATA_WIDTH`, 16: bits per row.
- `IDX_W`, `max(1, $clog2(NUM_ROWS))`: derived, row-index width.

Ports (reset rst_ni, asynchronous, active-low; clock clk_i):
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `enable_i`  in  1  global enable; no handshake completes and no state changes while low.
- `clear_i`  in  1  synchronous flush.
- `valid_i`  in  1  input beat valid.
- `ready_o`  out  1  input beat accepted when `valid_i & ready_o`.
- `data_i`  in  `NUM_ROWS×DATA_WIDTH`  row-parallel beat.
- `strb_i`  in  `NUM_ROWS`  per-row strobe.
- `valid_o`  out  1  output row valid.
- `ready_i`  in  1  downstream ready.
- `data_o`  out  `DATA_WIDTH`  current row.
- `idx_o`  out  `IDX_W`  row index of `data_o`.
- `last_o`  out  1  current row is the last pending row of its beat.

## Operation
- State: `buf_q` holds `NUM_ROWS×DATA_WIDTH` data and `pend_q` holds `NUM_ROWS` pending bits. There is no other FSM state: the block is EMPTY when `pend_q==0` and BUSY otherwise.
- Selection: `idx_o` is the index of the lowest set bit of `pend_q`, or 0 when empty. `data_o` is `buf_q[idx_o]`, or 0 when empty.
- `valid_o = enable_i & |pend_q`.
- `last_o = valid_o & ($countones(pend_q)==1)`.
- Output handshake `oh = valid_o & ready_i` clears `pend_q[idx_o]`.
- `ready_o = enable_i & ~clear_i & (pend_q==0 | (oh & last_o))`. A new beat can load in the same cycle the last row leaves.
- Input handshake `ih = valid_i & ready_o`:
  - `pend_q <= strb_i`.
  - `buf_q[r] <= data_i[r]` only for rows with `strb_i[r]` set; unstrobed rows keep their old value.
- A beat with `strb_i==0` is accepted and dropped. It produces no output, and the block stays EMPTY.
- `clear_i` (with `enable_i` either way): `pend_q <= 0` and `buf_q <= 0`. Clear has priority over both handshakes, so a beat presented during clear is not accepted.
- Rows are never reordered or duplicated. Unstrobed rows are never emitted.

## Timing
- Reset values: `pend_q=0`, `buf_q=0`. Therefore `valid_o=0`, `data_o=0`, `idx_o=0`, `last_o=0`, and `ready_o=enable_i`.
- Latency: a beat accepted at edge k presents its first row in cycle k+1 (registered, no combinational valid_i→valid_o path).
- Throughput: one row per cycle under continuous `ready_i`. A beat with s strobed rows occupies s cycles. Back-to-back beats run without a bubble.
- `ready_i` low: `data_o`, `idx_o` and `last_o` hold stable until the handshake. `valid_o` does not drop while `enable_i` stays high.
- `enable_i` low: `valid_o=0` and `ready_o=0`, and the registers freeze. When `enable_i` returns, output resumes on the same row.
- `ready_o` depends combinationally on `ready_i` (last-row overlap only).
- Reset asserted mid-beat: pending rows are discarded immediately (asynchronous).

## Structure
- No new typedefs. `IDX_W` is computed locally.
- One sub-module: common_cells `lzc` in trailing-zero mode (`MODE=0`, `WIDTH=NUM_ROWS`) produces `idx_o` and the empty flag from `pend_q`.
- Popcount-equals-one for `last_o` uses the expression `(pend_q & (pend_q-1))==0 & |pend_q`; no popcount module.

## Test plan
- Full strobe: `NUM_ROWS=4`, `strb_i=4'b1111`, data {D,C,B,A}, `ready_i=1` → rows A,B,C,D on cycles k+1..k+4 with `idx_o` 0,1,2,3 and `last_o` only on D. `ready_o` is low on k+1..k+3 and high on k+4.
- Sparse strobe: `strb_i=4'b1010` → exactly 2 rows, `idx_o`=1 then 3, `last_o` on `idx_o`=3. `strb_i=0` → accepted, `valid_o` never rises.
- Back-to-back: two beats `1111` then `0011` with `valid_i` held high → 6 consecutive output cycles with no bubble; the second beat is accepted in the cycle its predecessor's last row handshakes.
- Backpressure: `ready_i` toggled pseudo-randomly over 100 beats → scoreboard sees every strobed row exactly once, in order. Outputs stay stable while `valid_o & ~ready_i`.
- Enable/clear:
  - `enable_i=0` mid-beat for 3 cycles → `valid_o=0`; the same row resumes afterwards.
  - `clear_i` with 2 rows pending and `valid_i=1` → next cycle `valid_o=0`, the beat is not accepted, and `ready_o=1`.
- Async reset mid-beat → `valid_o=0` and `data_o=0` immediately; the first beat after reset is serialized correctly.

Source files
------------

// File: rtl/softex_row_serializer_pkg.sv
// Shared defaults for the softex row serializer slice.
package softex_row_serializer_pkg;

    // Default geometry of one row-parallel beat.
    localparam int unsigned SRS_DEF_NUM_ROWS   = 4;
    localparam int unsigned SRS_DEF_DATA_WIDTH = 16;

    // Counting direction selector for the zero counter: 0 counts trailing
    // zeros (index of lowest set bit), 1 counts leading zeros.
    localparam bit LZC_MODE_TRAILING = 1'b0;
    localparam bit LZC_MODE_LEADING  = 1'b1;

endpackage

// File: rtl/softex_row_serializer_lzc.sv
// Leading/trailing zero counter with empty flag. In trailing mode the count
// equals the index of the lowest set bit; an all-zero input reports 0.
module softex_row_serializer_lzc
    import softex_row_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter bit          MODE  = LZC_MODE_TRAILING,
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             empty_o
);

    // Scan the vector so the last match written is the wanted bit position.
    always_comb begin
        cnt_o = '0;
        if (MODE == LZC_MODE_TRAILING) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in_i[i]) begin
                    cnt_o = CNT_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (in_i[i]) begin
                    cnt_o = CNT_W'(WIDTH - 1 - i);
                end
            end
        end
    end

    assign empty_o = ~|in_i;

endmodule

// File: rtl/softex_row_serializer.sv
// Row serializer: takes one strobed beat of NUM_ROWS rows and emits only the
// strobed rows, lowest index first, one per cycle, tagged with index and a
// last-row flag. The only state is the row buffer and its pending mask.
module softex_row_serializer
    import softex_row_serializer_pkg::*;
#(
    parameter int unsigned NUM_ROWS   = SRS_DEF_NUM_ROWS,
    parameter int unsigned DATA_WIDTH = SRS_DEF_DATA_WIDTH,
    localparam int unsigned IDX_W     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           enable_i,
    input  logic                           clear_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  logic [NUM_ROWS*DATA_WIDTH-1:0] data_i,
    input  logic [NUM_ROWS-1:0]            strb_i,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [DATA_WIDTH-1:0]          data_o,
    output logic [IDX_W-1:0]               idx_o,
    output logic                           last_o
);

    logic [NUM_ROWS-1:0]   pend_q;
    logic [NUM_ROWS-1:0]   pend_next;
    logic [DATA_WIDTH-1:0] buf_q    [NUM_ROWS];
    logic [DATA_WIDTH-1:0] buf_next [NUM_ROWS];

    logic [IDX_W-1:0] sel_idx;
    logic             pend_empty;
    logic             single_pend;
    logic             out_hs;
    logic             in_hs;

    // Lowest pending row is the next one out.
    softex_row_serializer_lzc #(
        .WIDTH (NUM_ROWS),
        .MODE  (LZC_MODE_TRAILING)
    ) i_lzc (
        .in_i    (pend_q),
        .cnt_o   (sel_idx),
        .empty_o (pend_empty)
    );

    // Exactly one bit set: clearing the lowest set bit leaves nothing.
    assign single_pend = ((pend_q & (pend_q - NUM_ROWS'(1))) == '0) & ~pend_empty;

    assign valid_o = enable_i & ~pend_empty;
    assign last_o  = valid_o & single_pend;
    assign idx_o   = sel_idx;
    assign data_o  = pend_empty ? '0 : buf_q[sel_idx];

    assign out_hs  = valid_o & ready_i;
    // A new beat may load while the final row of the current beat leaves.
    assign ready_o = enable_i & ~clear_i & (pend_empty | (out_hs & last_o));
    assign in_hs   = valid_i & ready_o;

    // Pending mask update: clear wins, enable low freezes, a load overrides
    // the retirement of the last row in the overlap cycle.
    always_comb begin
        pend_next = pend_q;
        if (clear_i) begin
            pend_next = '0;
        end else if (enable_i) begin
            if (out_hs) begin
                pend_next[sel_idx] = 1'b0;
            end
            if (in_hs) begin
                pend_next = strb_i;
            end
        end
    end

    // Per-row buffer update: only strobed rows are overwritten on a load.
    for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
        assign buf_next[gi] = clear_i                ? '0 :
                              (in_hs && strb_i[gi]) ? data_i[gi*DATA_WIDTH +: DATA_WIDTH] :
                                                      buf_q[gi];
    end

    // State registers with asynchronous discard of everything pending.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                buf_q[r] <= '0;
            end
        end else begin
            pend_q <= pend_next;
            for (int r = 0; r < NUM_ROWS; r++) begin
                buf_q[r] <= buf_next[r];
            end
        end
    end

endmodule

// File: tb/tb_softex_row_serializer.sv
// Self-checking bench for softex_row_serializer: directed scenarios plus a
// randomized backpressure run, all rows checked against a scoreboard queue.
module tb_softex_row_serializer;

    localparam int NR = 4;
    localparam int DW = 16;

    typedef struct {
        logic [1:0]    idx;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic              clk_i    = 1'b0;
    logic              rst_ni   = 1'b0;
    logic              enable_i = 1'b0;
    logic              clear_i  = 1'b0;
    logic              valid_i  = 1'b0;
    logic              ready_o;
    logic [NR*DW-1:0]  data_i   = '0;
    logic [NR-1:0]     strb_i   = '0;
    logic              valid_o;
    logic              ready_i;
    logic [DW-1:0]     data_o;
    logic [1:0]        idx_o;
    logic              last_o;

    logic ready_fix = 1'b0;
    logic rnd_ready = 1'b0;
    logic rnd_bit   = 1'b0;
    assign ready_i = rnd_ready ? rnd_bit : ready_fix;

    int checks       = 0;
    int failures     = 0;
    int rows_pushed  = 0;
    int rows_seen    = 0;
    int rows_dropped = 0;

    exp_t exp_q[$];

    softex_row_serializer #(
        .NUM_ROWS   (NR),
        .DATA_WIDTH (DW)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .enable_i (enable_i),
        .clear_i  (clear_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data_i   (data_i),
        .strb_i   (strb_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .data_o   (data_o),
        .idx_o    (idx_o),
        .last_o   (last_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic flush_model();
        rows_dropped += exp_q.size();
        exp_q.delete();
    endtask

    // Present a beat until it is accepted; waited counts edges consumed.
    task automatic send_beat(input logic [NR*DW-1:0] d, input logic [NR-1:0] s, output int waited);
        logic acc;
        valid_i = 1'b1;
        data_i  = d;
        strb_i  = s;
        waited  = 0;
        acc     = 1'b0;
        while (!acc) begin
            @(negedge clk_i);
            acc = ready_o;
            @(posedge clk_i);
            #1;
            waited++;
            if (!acc && waited > 300) begin
                check_eq("accept_timeout", 0, 1);
                break;
            end
        end
        valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || valid_o) && n < 400) begin
            tick();
            n++;
        end
        check_eq("drain", 64'(exp_q.size()), 0);
    endtask

    // Model side: record the rows of every beat the DUT is about to accept.
    always @(negedge clk_i) begin : acceptor
        int hi;
        if (rst_ni && valid_i && ready_o) begin
            hi = -1;
            for (int r = 0; r < NR; r++) begin
                if (strb_i[r]) hi = r;
            end
            for (int r = 0; r < NR; r++) begin
                if (strb_i[r]) begin
                    exp_q.push_back('{idx: 2'(r), data: data_i[r*DW +: DW], last: (r == hi)});
                    rows_pushed++;
                end
            end
            $display("beat accepted strb=%b data=%h t=%0t", strb_i, data_i, $time);
        end
    end

    // Output side: compare each handshaken row and check hold stability.
    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_d;
    logic [1:0]    hold_i;
    logic          hold_l;
    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (hold_v && valid_o) begin
            check_eq("hold_data", 64'(data_o), 64'(hold_d));
            check_eq("hold_idx", 64'(idx_o), 64'(hold_i));
            check_eq("hold_last", 64'(last_o), 64'(hold_l));
        end
        hold_v = valid_o & ~ready_i;
        hold_d = data_o;
        hold_i = idx_o;
        hold_l = last_o;
        if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_row", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("row_idx", 64'(idx_o), 64'(e.idx));
                check_eq("row_data", 64'(data_o), 64'(e.data));
                check_eq("row_last", 64'(last_o), 64'(e.last));
                rows_seen++;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int w;
        int w2;
        logic [DW-1:0] rowv [NR];

        // Reset state
        rst_ni   = 1'b0;
        enable_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("rst_valid", 64'(valid_o), 0);
        check_eq("rst_data", 64'(data_o), 0);
        check_eq("rst_idx", 64'(idx_o), 0);
        check_eq("rst_last", 64'(last_o), 0);
        check_eq("rst_ready_en", 64'(ready_o), 1);
        enable_i = 1'b0;
        #1;
        check_eq("rst_ready_dis", 64'(ready_o), 0);
        enable_i = 1'b1;
        tick();
        rst_ni = 1'b1;
        #1;
        check_eq("idle_ready", 64'(ready_o), 1);

        // Full strobe, rows A..D
        ready_fix = 1'b1;
        rowv[0] = 16'hA0A0; rowv[1] = 16'hB0B1; rowv[2] = 16'hC0C2; rowv[3] = 16'hD0D3;
        send_beat({rowv[3], rowv[2], rowv[1], rowv[0]}, 4'b1111, w);
        check_eq("full_accept_wait", 64'(w), 1);
        #1;
        for (int i = 0; i < NR; i++) begin
            check_eq("full_valid", 64'(valid_o), 1);
            check_eq("full_idx", 64'(idx_o), 64'(i));
            check_eq("full_data", 64'(data_o), 64'(rowv[i]));
            check_eq("full_last", 64'(last_o), (i == 3) ? 1 : 0);
            check_eq("full_ready", 64'(ready_o), (i == 3) ? 1 : 0);
            tick();
            #1;
        end
        check_eq("full_done_valid", 64'(valid_o), 0);

        // Sparse strobe 1010
        send_beat({16'hE003, 16'hE002, 16'hE001, 16'hE000}, 4'b1010, w);
        #1;
        check_eq("sparse_valid0", 64'(valid_o), 1);
        check_eq("sparse_idx0", 64'(idx_o), 1);
        check_eq("sparse_data0", 64'(data_o), 64'h0E001);
        check_eq("sparse_last0", 64'(last_o), 0);
        tick();
        #1;
        check_eq("sparse_idx1", 64'(idx_o), 3);
        check_eq("sparse_data1", 64'(data_o), 64'h0E003);
        check_eq("sparse_last1", 64'(last_o), 1);
        tick();
        #1;
        check_eq("sparse_done_valid", 64'(valid_o), 0);

        // Zero strobe: accepted, produces nothing
        send_beat({4{16'h5A5A}}, 4'b0000, w);
        check_eq("zero_accept_wait", 64'(w), 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("zero_valid", 64'(valid_o), 0);
            check_eq("zero_ready", 64'(ready_o), 1);
            tick();
        end

        // Back-to-back beats 1111 then 0011
        send_beat({16'h1113, 16'h1112, 16'h1111, 16'h1110}, 4'b1111, w);
        send_beat({16'h2223, 16'h2222, 16'h2221, 16'h2220}, 4'b0011, w2);
        check_eq("b2b_second_wait", 64'(w2), 4);
        #1;
        check_eq("b2b_valid0", 64'(valid_o), 1);
        check_eq("b2b_idx0", 64'(idx_o), 0);
        check_eq("b2b_data0", 64'(data_o), 64'h2220);
        tick();
        #1;
        check_eq("b2b_valid1", 64'(valid_o), 1);
        check_eq("b2b_idx1", 64'(idx_o), 1);
        check_eq("b2b_last1", 64'(last_o), 1);
        tick();
        #1;
        check_eq("b2b_done_valid", 64'(valid_o), 0);

        // Enable low mid-beat, resume on same row
        send_beat({16'hF003, 16'hF002, 16'hF001, 16'hF000}, 4'b1111, w);
        #1;
        check_eq("en_idx_before", 64'(idx_o), 0);
        tick();
        enable_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("en_low_valid", 64'(valid_o), 0);
            check_eq("en_low_ready", 64'(ready_o), 0);
            tick();
        end
        enable_i = 1'b1;
        #1;
        check_eq("en_resume_valid", 64'(valid_o), 1);
        check_eq("en_resume_idx", 64'(idx_o), 1);
        check_eq("en_resume_data", 64'(data_o), 64'hF001);
        wait_drain();

        // Clear with two rows pending and a beat offered
        ready_fix = 1'b0;
        send_beat({16'h6663, 16'h6662, 16'h6661, 16'h6660}, 4'b0011, w);
        #1;
        check_eq("clr_pre_valid", 64'(valid_o), 1);
        clear_i = 1'b1;
        valid_i = 1'b1;
        strb_i  = 4'b1111;
        data_i  = {16'h7773, 16'h7772, 16'h7771, 16'h7770};
        #1;
        check_eq("clr_ready_during", 64'(ready_o), 0);
        tick();
        clear_i = 1'b0;
        flush_model();
        #1;
        check_eq("clr_valid_after", 64'(valid_o), 0);
        check_eq("clr_ready_after", 64'(ready_o), 1);
        check_eq("clr_data_after", 64'(data_o), 0);
        valid_i = 1'b0;
        tick();

        // Asynchronous reset mid-beat
        send_beat({16'h8883, 16'h8882, 16'h8881, 16'h8880}, 4'b1111, w);
        tick();
        rst_ni = 1'b0;
        flush_model();
        #1;
        check_eq("arst_valid", 64'(valid_o), 0);
        check_eq("arst_data", 64'(data_o), 0);
        check_eq("arst_idx", 64'(idx_o), 0);
        tick();
        rst_ni = 1'b1;
        #1;
        check_eq("arst_ready", 64'(ready_o), 1);
        ready_fix = 1'b1;
        send_beat({16'h9993, 16'h9992, 16'h9991, 16'h9990}, 4'b0110, w);
        wait_drain();

        // Random backpressure over 100 beats
        rnd_ready = 1'b1;
        for (int b = 0; b < 100; b++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) tick();
            send_beat({$urandom(), $urandom()}, 4'($urandom_range(0, 15)), w);
        end
        wait_drain();
        rnd_ready = 1'b0;

        check_eq("rows_total", 64'(rows_seen), 64'(rows_pushed - rows_dropped));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
